// File: rtl/br_resolve_pc.sv
// EX-stage branch resolution, 2-bit-counter BHT direction predictor and fetch PC
// register for the pipelined RV32I core.
module br_resolve_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_DEPTH = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_if_is_br,
  input  logic [31:0] i_if_br_target,
  output logic [31:0] o_pc,
  output logic        o_if_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_flush,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_STK = 2'b11;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_ctr;
  logic [1:0]       ex_ctr_next;
  logic             cond;
  logic             ex_br;
  logic             taken;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [31:0]      pc_next;

  // BLTU/BGEU are the only encodings with funct3[1] set that compare.
  assign o_br_un = i_ex_funct3[1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cond = 1'b0;
    case (i_ex_funct3)
      3'b000:  cond = i_br_equal;
      3'b001:  cond = ~i_br_equal;
      3'b100:  cond = i_br_less;
      3'b101:  cond = ~i_br_less;
      3'b110:  cond = i_br_less;
      3'b111:  cond = ~i_br_less;
      default: cond = 1'b0;
    endcase
  end

  assign ex_br    = i_ex_valid & i_ex_is_br;
  assign taken    = i_ex_valid & (i_ex_is_jmp | (i_ex_is_br & cond));
  // Jumps are never predicted, so they always redirect.
  assign redirect = i_ex_valid & (i_ex_is_jmp | (i_ex_is_br & (cond != i_ex_pred_taken)));
  assign o_flush  = redirect;

  assign redirect_pc = taken ? i_ex_target : i_ex_pc + 32'd4;

  assign if_idx          = o_pc[IDX_W+1:2];
  assign o_if_pred_taken = i_if_is_br & bht[if_idx][1];

  always_comb begin
    pc_next = o_pc + 32'd4;
    if (redirect)             pc_next = redirect_pc;
    else if (i_stall)         pc_next = o_pc;
    else if (o_if_pred_taken) pc_next = i_if_br_target;
  end

  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_ctr = bht[ex_idx];

  always_comb begin
    ex_ctr_next = ex_ctr;
    if (cond) begin
      if (ex_ctr != CTR_STK) ex_ctr_next = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != CTR_SNT) ex_ctr_next = ex_ctr - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc <= RESET_PC;
    end else begin
      o_pc <= pc_next;
    end
  end

  // NOTE: the BHT is built from flops and must start weakly-not-taken, so it is
  // reset like any other register rather than left to power-up values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_WNT;
    end else if (ex_br) begin
      bht[ex_idx] <= ex_ctr_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_br_cnt      <= 32'd0;
      o_mispred_cnt <= 32'd0;
    end else begin
      if (ex_br)    o_br_cnt      <= o_br_cnt + 32'd1;
      if (redirect) o_mispred_cnt <= o_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_br_resolve_pc.sv
// Self-checking bench for br_resolve_pc: directed table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_br_resolve_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        if_is_br;
  logic [31:0] if_br_target;
  logic [31:0] pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_is_br;
  logic        ex_is_jmp;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        br_un;
  logic        br_less;
  logic        br_equal;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  br_resolve_pc dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_stall         (stall),
    .i_if_is_br      (if_is_br),
    .i_if_br_target  (if_br_target),
    .o_pc            (pc),
    .o_if_pred_taken (if_pred_taken),
    .i_ex_valid      (ex_valid),
    .i_ex_is_br      (ex_is_br),
    .i_ex_is_jmp     (ex_is_jmp),
    .i_ex_funct3     (ex_funct3),
    .i_ex_pc         (ex_pc),
    .i_ex_target     (ex_target),
    .i_ex_pred_taken (ex_pred_taken),
    .o_br_un         (br_un),
    .i_br_less       (br_less),
    .i_br_equal      (br_equal),
    .o_flush         (flush),
    .o_br_cnt        (br_cnt),
    .o_mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid, is_br, is_jmp;
    logic [2:0] f3;
    logic       less, equal, pred;
    logic       exp_un, exp_flush, exp_taken;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jmp, input logic [2:0] f3,
                        input logic [31:0] epc, input logic [31:0] tgt, input logic pred);
    ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_funct3 = f3;
    ex_pc = epc; ex_target = tgt; ex_pred_taken = pred;
  endtask

  task automatic ex_idle();
    set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 0);
    br_less = 0; br_equal = 0;
  endtask

  // JAL from address 0 to dst, used to steer the fetch PC.
  task automatic jump_to(input logic [31:0] dst);
    set_ex(1, 0, 1, 3'b000, 32'h0, dst, 0);
    tick();
    ex_idle();
  endtask

  // Behavioural model state for the random phase.
  logic [31:0] m_pc;
  int          m_bht[64];
  logic [31:0] m_br, m_mis;

  function automatic logic branch_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [31:0] exp_pc, exp_br, exp_mis;
  logic [31:0] operands[5];

  initial begin
    operands = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5};

    vecs[0]  = '{1,1,0,3'b000,0,1,0, 0,1,1};
    vecs[1]  = '{1,1,0,3'b000,0,0,0, 0,0,0};
    vecs[2]  = '{1,1,0,3'b001,0,1,1, 0,1,0};
    vecs[3]  = '{1,1,0,3'b001,0,0,1, 0,0,1};
    vecs[4]  = '{1,1,0,3'b100,1,0,1, 0,0,1};
    vecs[5]  = '{1,1,0,3'b101,1,0,0, 0,0,0};
    vecs[6]  = '{1,1,0,3'b101,0,0,0, 0,1,1};
    vecs[7]  = '{1,1,0,3'b110,1,0,0, 1,1,1};
    vecs[8]  = '{1,1,0,3'b111,1,0,1, 1,1,0};
    vecs[9]  = '{1,1,0,3'b011,1,1,0, 1,0,0};
    vecs[10] = '{0,1,0,3'b000,0,1,1, 0,0,0};
    vecs[11] = '{1,0,1,3'b000,0,0,1, 0,1,1};
    vecs[12] = '{1,0,0,3'b000,0,1,0, 0,0,0};
    vecs[13] = '{1,0,1,3'b010,0,0,0, 1,1,1};

    rst = 1; stall = 0; if_is_br = 0; if_br_target = 0;
    ex_idle();
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_br_cnt", br_cnt, 32'h0);
    check("reset_mispred_cnt", mispred_cnt, 32'h0);
    check("reset_flush", flush, 1'b0);
    tick(); tick();
    rst = 0;

    // Free-running fetch; counters are weakly-not-taken so no prediction.
    if_is_br = 1; if_br_target = 32'hDEAD_0000;
    check("seq_pc0", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      check("seq_pred_off", if_pred_taken, 1'b0);
      check("seq_flush_off", flush, 1'b0);
      tick();
      check("seq_pc_step", pc, 32'(4 * i));
    end
    if_is_br = 0;

    // Directed decode table; fetch path stays sequential.
    exp_pc = 32'd12; exp_br = 0; exp_mis = 0;
    foreach (vecs[i]) begin
      set_ex(vecs[i].valid, vecs[i].is_br, vecs[i].is_jmp, vecs[i].f3, 32'h100, 32'h200, vecs[i].pred);
      br_less = vecs[i].less; br_equal = vecs[i].equal;
      #1;
      check($sformatf("tbl%0d_br_un", i), br_un, vecs[i].exp_un);
      check($sformatf("tbl%0d_flush", i), flush, vecs[i].exp_flush);
      if (vecs[i].exp_flush) exp_pc = vecs[i].exp_taken ? 32'h200 : 32'h104;
      else                   exp_pc = exp_pc + 32'd4;
      if (vecs[i].valid && vecs[i].is_br) exp_br = exp_br + 1;
      if (vecs[i].exp_flush) exp_mis = exp_mis + 1;
      tick();
      check($sformatf("tbl%0d_pc", i), pc, exp_pc);
      check($sformatf("tbl%0d_br_cnt", i), br_cnt, exp_br);
      check($sformatf("tbl%0d_mis_cnt", i), mispred_cnt, exp_mis);
    end
    ex_idle();
    rst = 1; #2; rst = 0;

    // BLT taken, predicted not taken: mispredict.
    set_ex(1, 1, 0, 3'b100, 32'h40, 32'h80, 0);
    #1 check("blt_br_un", br_un, 1'b0);
    br_less = 1;
    #1 check("blt_flush", flush, 1'b1);
    tick();
    check("blt_pc", pc, 32'h80);
    check("blt_mis_cnt", mispred_cnt, 32'd1);
    check("blt_br_cnt", br_cnt, 32'd1);
    ex_idle();
    #1 check("blt_flush_clear", flush, 1'b0);
    jump_to(32'h40);
    if_is_br = 1; if_br_target = 32'h1234_5670;
    #1 check("bht16_pred", if_pred_taken, 1'b1);
    tick();
    check("bht16_pc", pc, 32'h1234_5670);
    if_is_br = 0;

    // BGEU taken, predicted taken: no flush, fetch path continues.
    set_ex(1, 1, 0, 3'b111, 32'h40, 32'h100, 1);
    br_less = 0;
    #1 check("bgeu_br_un", br_un, 1'b1);
    check("bgeu_flush", flush, 1'b0);
    tick();
    check("bgeu_pc", pc, 32'h1234_5674);
    check("bgeu_br_cnt", br_cnt, 32'd2);
    check("bgeu_mis_cnt", mispred_cnt, 32'd2);

    // BEQ at 0x20 taken three times, then once not taken: saturates at 11, falls to 10.
    set_ex(1, 1, 0, 3'b000, 32'h20, 32'h300, 1);
    br_equal = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("beq_taken_flush", flush, 1'b0);
      tick();
    end
    br_equal = 0;
    #1 check("beq_nt_flush", flush, 1'b1);
    tick();
    check("beq_nt_pc", pc, 32'h24);
    check("beq_br_cnt", br_cnt, 32'd6);
    check("beq_mis_cnt", mispred_cnt, 32'd3);
    ex_idle();
    jump_to(32'h20);
    if_is_br = 1; if_br_target = 32'hABCD_0000;
    #1 check("bht8_sat_pred", if_pred_taken, 1'b1);
    tick();
    check("bht8_pc", pc, 32'hABCD_0000);
    if_is_br = 0;

    // JAL under stall: redirect wins, no BHT training.
    stall = 1;
    set_ex(1, 0, 1, 3'b000, 32'h60, 32'h60, 1);
    #1 check("jal_stall_flush", flush, 1'b1);
    tick();
    check("jal_stall_pc", pc, 32'h60);
    check("jal_mis_cnt", mispred_cnt, 32'd5);
    check("jal_br_cnt", br_cnt, 32'd6);
    ex_idle();
    if_is_br = 1; if_br_target = 32'h0000_0999;
    #1 check("jal_bht_untrained", if_pred_taken, 1'b0);
    tick();
    check("stall_hold_pc", pc, 32'h60);
    stall = 0;
    tick();
    check("unstall_pc", pc, 32'h64);
    if_is_br = 0;

    // Illegal funct3 with pred=1: not taken, redirect to ex_pc+4, counter decrements.
    set_ex(1, 1, 0, 3'b010, 32'h20, 32'h500, 1);
    br_less = 1; br_equal = 1;
    #1 check("ill_flush", flush, 1'b1);
    check("ill_br_un", br_un, 1'b1);
    tick();
    check("ill_pc", pc, 32'h24);
    check("ill_br_cnt", br_cnt, 32'd7);
    check("ill_mis_cnt", mispred_cnt, 32'd6);
    ex_idle();
    jump_to(32'h20);
    if_is_br = 1;
    #1 check("ill_bht_dec", if_pred_taken, 1'b0);
    if_is_br = 0;

    // Reset in the middle of a redirect cycle.
    set_ex(1, 0, 1, 3'b000, 32'h0, 32'h700, 0);
    #1 check("mid_flush", flush, 1'b1);
    #2 rst = 1;
    #1 check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_br_cnt", br_cnt, 32'h0);
    check("mid_rst_mis_cnt", mispred_cnt, 32'h0);
    ex_idle();
    #1 check("mid_rst_flush", flush, 1'b0);
    set_ex(1, 0, 1, 3'b000, 32'h0, 32'h700, 0);
    tick();
    check("rst_held_pc", pc, 32'h0);
    ex_idle();
    rst = 0;

    // PC wrap at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    check("wrap_top_pc", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc, 32'h0);

    // Randomized run against the behavioural model.
    rst = 1; #2; rst = 0;
    m_pc = 32'h0; m_br = 0; m_mis = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      logic        c, m_pred, m_taken, m_redir;
      int          kind, idx;
      a = operands[$urandom_range(0, 4)];
      b = operands[$urandom_range(0, 4)];
      kind = $urandom_range(0, 3);
      set_ex($urandom_range(0, 4) != 0, kind == 1 || kind == 2, kind == 3,
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255)) << 2,
             $urandom, $urandom_range(0, 1) == 1);
      stall = $urandom_range(0, 4) == 0;
      if_is_br = $urandom_range(0, 1) == 1;
      if_br_target = $urandom;
      #1;
      br_less  = br_un ? (a < b) : ($signed(a) < $signed(b));
      br_equal = a == b;
      #1;
      c       = branch_cond(ex_funct3, a, b);
      m_pred  = if_is_br && (m_bht[(m_pc >> 2) % 64] >= 2);
      m_taken = ex_valid && (ex_is_jmp || (ex_is_br && c));
      m_redir = ex_valid && (ex_is_jmp || (ex_is_br && (c != ex_pred_taken)));
      check("rnd_flush", flush, m_redir);
      check("rnd_pred", if_pred_taken, m_pred);
      if (m_redir)     m_pc = m_taken ? ex_target : ex_pc + 32'd4;
      else if (stall)  m_pc = m_pc;
      else if (m_pred) m_pc = if_br_target;
      else             m_pc = m_pc + 32'd4;
      if (ex_valid && ex_is_br) begin
        idx = (ex_pc >> 2) % 64;
        if (c) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
        else   m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
        m_br = m_br + 1;
      end
      if (m_redir) m_mis = m_mis + 1;
      tick();
      check("rnd_pc", pc, m_pc);
      check("rnd_br_cnt", br_cnt, m_br);
      check("rnd_mis_cnt", mispred_cnt, m_mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
